// File: rtl/fp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp_arb_pkg
// Brief    : Shared state encoding, constants and width helpers for the
//            floating-point adder arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fp_arb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE    = 3'd0;
    localparam state_t c_LOAD    = 3'd1;
    localparam state_t c_WAIT    = 3'd2;
    localparam state_t c_ACK     = 3'd3;
    localparam state_t c_RECOVER = 3'd4;
    localparam state_t c_RESP    = 3'd5;

    // Quiet NaN returned when the adder had to be recovered
    localparam logic [31:0] c_FP_QNAN = 32'h7FC0_0000;

    // Bits needed to count from 0 up to n inclusive
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; searches upward from ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_grant_idx,
    output logic                    o_valid
);

    localparam int c_IDX_W = $clog2(NREQ);

    int                 w_pos;
    logic [c_IDX_W-1:0] w_pos_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_pos       = 0;
        w_pos_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos     = (int'(i_ptr) + k) % NREQ;
            w_pos_idx = c_IDX_W'(w_pos);
            if (!o_valid && i_req[w_pos_idx]) begin
                o_valid            = 1'b1;
                o_grant[w_pos_idx] = 1'b1;
                o_grant_idx        = w_pos_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_adder_arbiter
// Brief    : Shares one single-precision adder between NREQ requesters with
//            round-robin arbitration, 4-phase adder handshake and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fp_adder_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TIMEOUT  = 256,
    parameter int RST_HOLD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [32*NREQ-1:0]      req_a,
    input  logic [32*NREQ-1:0]      req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [31:0]             rsp_data,
    output logic                    rsp_error,
    input  logic [NREQ-1:0]         rsp_ack,
    output logic                    add_load,
    output logic [31:0]             add_a,
    output logic [31:0]             add_b,
    input  logic [31:0]             add_result,
    input  logic                    add_result_ready,
    output logic                    add_result_ack,
    output logic                    add_reset,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int c_IDX_W  = $clog2(NREQ);
    localparam int c_WDOG_W = cnt_width(TIMEOUT);
    localparam int c_HOLD_W = cnt_width(RST_HOLD);

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_grant_id;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [31:0]         r_result;
    logic                r_error;
    logic [c_WDOG_W-1:0] r_wdog;
    logic [c_HOLD_W-1:0] r_hold;

    logic [NREQ-1:0]     w_grant;
    logic [c_IDX_W-1:0]  w_grant_idx;
    logic                w_grant_vld;
    logic [31:0]         w_op_a;
    logic [31:0]         w_op_b;
    logic                w_rsp_ack;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_valid     (w_grant_vld)
    );

    // One-hot operand select of the winning requester
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_op_a = req_a[32*i +: 32];
                w_op_b = req_b[32*i +: 32];
            end
        end
    end

    // Only the owner's ack bit can close the response
    assign w_rsp_ack = |(rsp_ack & rsp_valid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_rr_ptr   <= c_IDX_W'(NREQ - 1);
            r_grant_id <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_error    <= 1'b0;
            r_wdog     <= '0;
            r_hold     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_vld) begin
                        r_grant_id <= w_grant_idx;
                        r_a        <= w_op_a;
                        r_b        <= w_op_b;
                        r_state    <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_wdog  <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // A result arriving on the timeout cycle still counts
                    if (add_result_ready) begin
                        r_result <= add_result;
                        r_error  <= 1'b0;
                        r_state  <= c_ACK;
                    end else if (r_wdog == c_WDOG_W'(TIMEOUT - 1)) begin
                        r_hold  <= '0;
                        r_state <= c_RECOVER;
                    end else begin
                        r_wdog <= r_wdog + c_WDOG_W'(1);
                    end
                end
                c_ACK: begin
                    if (!add_result_ready) begin
                        r_state <= c_RESP;
                    end
                end
                c_RECOVER: begin
                    if (r_hold == c_HOLD_W'(RST_HOLD - 1)) begin
                        r_result <= c_FP_QNAN;
                        r_error  <= 1'b1;
                        r_state  <= c_RESP;
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end
                c_RESP: begin
                    if (w_rsp_ack) begin
                        r_rr_ptr <= r_grant_id;
                        r_error  <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == c_RESP) begin
            rsp_valid[r_grant_id] = 1'b1;
        end
    end

    assign req_ready      = (reset && r_state == c_IDLE) ? w_grant : '0;
    assign rsp_data       = r_result;
    assign rsp_error      = r_error;
    assign add_load       = (r_state == c_LOAD);
    assign add_a          = r_a;
    assign add_b          = r_b;
    assign add_result_ack = (r_state == c_ACK);
    assign add_reset      = reset & (r_state != c_RECOVER);
    assign busy           = (r_state != c_IDLE);
    assign grant_id       = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_adder_arbiter
// Brief    : Scoreboard bench for fp_adder_arbiter with a behavioural adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_adder_arbiter;

    localparam int NREQ     = 4;
    localparam int TIMEOUT  = 256;
    localparam int RST_HOLD = 2;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_error;
    logic [NREQ-1:0]      rsp_ack;
    logic                 add_load;
    logic [31:0]          add_a;
    logic [31:0]          add_b;
    logic [31:0]          add_result;
    logic                 add_result_ready;
    logic                 add_result_ack;
    logic                 add_reset;
    logic                 busy;
    logic [1:0]           grant_id;

    always #10 clk = ~clk;

    fp_adder_arbiter #(
        .NREQ     (NREQ),
        .TIMEOUT  (TIMEOUT),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_error        (rsp_error),
        .rsp_ack          (rsp_ack),
        .add_load         (add_load),
        .add_a            (add_a),
        .add_b            (add_b),
        .add_result       (add_result),
        .add_result_ready (add_result_ready),
        .add_result_ack   (add_result_ack),
        .add_reset        (add_reset),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t            exp_q [NREQ][$];
    int              inflight_q[$];
    int              grant_log[$];
    int              acc_cnt [NREQ];
    int              checks = 0;
    int              errors = 0;
    int              last_g = NREQ - 1;
    bit              hang = 1'b0;
    bit              ack_hold = 1'b0;
    int              ack_max = 0;
    logic [NREQ-1:0] stray_ack = '0;
    int              load_cnt = 0, load_cyc = 0, rst_fall_cyc = 0, last_rst_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Exact integer -> single-precision encoding (|v| < 2^24)
    function automatic logic [31:0] int_to_fp(input int v);
        logic [31:0] mag;
        logic        s;
        int          p;
        if (v == 0) return 32'd0;
        s   = (v < 0);
        mag = s ? 32'(-v) : 32'(v);
        p   = 0;
        for (int k = 0; k < 32; k++) if (mag[k]) p = k;
        return {s, 8'(127 + p), 23'(mag << (23 - p))};
    endfunction

    function automatic real sp2real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic int predict(input logic [NREQ-1:0] p, input int last);
        for (int k = 1; k <= NREQ; k++) if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        return 0;
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid[i]      = 1'b1;
        exp_q[i].push_back(x);
    endtask

    task automatic issue_rand(input int i);
        int ia, ib;
        ia = int'($urandom_range(0, 1048575)) - 524288;
        ib = int'($urandom_range(0, 1048575)) - 524288;
        issue(i, int_to_fp(ia), int_to_fp(ib), int_to_fp(ia + ib), 1'b0);
    endtask

    // One clock: sample at negedge, drop accepted requests just after posedge
    task automatic cycle();
        logic [NREQ-1:0] rdy, pend, eo;
        int a;
        @(negedge clk);
        rdy  = req_ready;
        pend = req_valid;
        if (reset && !busy && pend != '0) begin
            eo = '0;
            eo[predict(pend, last_g)] = 1'b1;
            check("grant", 32'(rdy), 32'(eo));
        end
        if (rdy != '0) begin
            a = -1;
            for (int k = 0; k < NREQ; k++) if (rdy[k] && a < 0) a = k;
            last_g = a;
            grant_log.push_back(a);
            inflight_q.push_back(a);
            acc_cnt[a]++;
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~rdy;
    endtask

    function automatic int pending_exp();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        while ((req_valid != '0 || busy || pending_exp() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_add_load"}, 32'(add_load), 32'd0);
        check({tag, "_add_ack"}, 32'(add_result_ack), 32'd0);
        check({tag, "_add_reset"}, 32'(add_reset), 32'd0);
        check({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_add_a"}, add_a, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b0;
        req_valid = '0;
        repeat (2) cycle();
        check_reset_outputs(tag);
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        inflight_q.delete();
        grant_log.delete();
        last_g = NREQ - 1;
    endtask

    // Behavioural adder: 4-phase result handshake, optional hang
    initial begin
        logic [31:0] la, lb;
        int cnt = 0, ncyc = 0, rst_run = 0;
        bit active = 1'b0, prev_ack = 1'b0;
        add_result_ready = 1'b0;
        add_result       = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (prev_ack && !add_result_ack) check("ack_4phase", 32'(add_result_ready), 32'd0);
            prev_ack = add_result_ack;
            if (!add_reset) begin
                if (reset) begin
                    if (rst_run == 0) rst_fall_cyc = ncyc;
                    rst_run++;
                end
                add_result_ready = 1'b0;
                active           = 1'b0;
            end else begin
                if (rst_run != 0) begin
                    last_rst_run = rst_run;
                    rst_run      = 0;
                end
                if (add_load) begin
                    load_cnt++;
                    load_cyc = ncyc;
                    active   = 1'b1;
                    cnt      = int'($urandom_range(1, 4));
                    la       = add_a;
                    lb       = add_b;
                end else if (active) begin
                    if (cnt > 1) cnt--;
                    else if (!hang) begin
                        add_result       = real2sp(sp2real(la) + sp2real(lb));
                        add_result_ready = 1'b1;
                        active           = 1'b0;
                    end
                end
                if (add_result_ready && add_result_ack) add_result_ready = 1'b0;
            end
        end
    end

    // Response monitor / scoreboard consumer, also drives rsp_ack
    initial begin
        logic [NREQ-1:0] rb, eo;
        bit   seen = 1'b0;
        int   dly = 0, idx;
        exp_t x;
        rb      = '0;
        rsp_ack = '0;
        forever begin
            @(negedge clk);
            if (reset && rsp_valid != '0) begin
                if (!seen) begin
                    seen = 1'b1;
                    dly  = int'($urandom_range(0, ack_max));
                    check("rsp_expected", 32'(inflight_q.size() != 0), 32'd1);
                    if (inflight_q.size() != 0) begin
                        idx = inflight_q.pop_front();
                        eo  = '0;
                        eo[idx] = 1'b1;
                        check("rsp_owner", 32'(rsp_valid), 32'(eo));
                        if (exp_q[idx].size() != 0) begin
                            x = exp_q[idx].pop_front();
                            check("rsp_data", rsp_data, x.data);
                            check("rsp_error", 32'(rsp_error), 32'(x.err));
                        end else begin
                            checks++;
                            errors++;
                            $display("FAIL rsp_scoreboard: requester %0d has no expected entry", idx);
                        end
                    end
                end
                if (!ack_hold && dly == 0) rb = rsp_valid;
                else if (dly > 0) dly--;
            end else begin
                rb   = '0;
                seen = 1'b0;
            end
            rsp_ack = rb | stray_ack;
        end
    end

    initial begin
        int n, a2, d, loads0;
        bit reissued;
        int e3 [5] = '{0, 1, 2, 3, 0};
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
        do_reset("por");

        // Single add with zero operand
        loads0 = load_cnt;
        issue(0, 32'h4248_0000, 32'h0000_0000, 32'h4248_0000, 1'b0);
        wait_quiet("t1_done", 200);
        check("t1_load_once", 32'(load_cnt - loads0), 32'd1);

        // 17.0 + 9.0 = 26.0
        issue(1, 32'h4188_0000, 32'h4110_0000, 32'h41D0_0000, 1'b0);
        wait_quiet("t2_done", 200);

        // All four held: strict rotation starting at 0
        do_reset("rst3");
        for (int i = 0; i < NREQ; i++) issue_rand(i);
        reissued = 1'b0;
        n = 0;
        while (grant_log.size() < 5 && n < 400) begin
            cycle();
            n++;
            if (!reissued && grant_log.size() >= 1) begin
                issue_rand(0);
                reissued = 1'b1;
            end
        end
        check("t3_grants_seen", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check($sformatf("t3_order%0d", k), 32'(grant_log[k]), 32'(e3[k]));
        wait_quiet("t3_done", 400);

        // Hung adder: watchdog recovery, then a normal add
        hang = 1'b1;
        issue(2, int_to_fp(5), int_to_fp(6), QNAN, 1'b1);
        wait_quiet("t4_done", 1000);
        hang = 1'b0;
        d = rst_fall_cyc - load_cyc;
        check("t4_wdog_delay", 32'(d >= TIMEOUT && d <= TIMEOUT + 2), 32'd1);
        check("t4_reset_hold", 32'(last_rst_run), 32'(RST_HOLD));
        issue_rand(2);
        wait_quiet("t4_after", 200);

        // Reset while waiting on the adder
        hang = 1'b1;
        issue_rand(1);
        repeat (10) cycle();
        check("t5_busy_before", 32'(busy), 32'd1);
        do_reset("t5");
        hang = 1'b0;
        issue_rand(3);
        issue_rand(0);
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin
            cycle();
            n++;
        end
        check("t5_first_winner", 32'(grant_log.size() != 0 ? grant_log[0] : -1), 32'd0);
        wait_quiet("t5_done", 400);

        // Withheld ack blocks new grants; stray ack ignored
        ack_hold = 1'b1;
        issue_rand(0);
        n = 0;
        while (!rsp_valid[0] && n < 200) begin
            cycle();
            n++;
        end
        check("t6_rsp_seen", 32'(rsp_valid), 32'h1);
        issue_rand(2);
        stray_ack = 4'b1000;
        a2 = acc_cnt[2];
        repeat (50) cycle();
        check("t6_no_accept", 32'(acc_cnt[2] - a2), 32'd0);
        check("t6_rsp_held", 32'(rsp_valid), 32'h1);
        stray_ack = '0;
        ack_hold  = 1'b0;
        n = 0;
        while (acc_cnt[2] == a2 && n < 50) begin
            cycle();
            n++;
        end
        check("t6_accept_after_ack", 32'(acc_cnt[2] - a2), 32'd1);
        wait_quiet("t6_done", 200);

        // Randomised traffic with ack delays and occasional withdrawn requests
        ack_max = 3;
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && exp_q[i].size() < 2 && $urandom_range(0, 3) == 0) begin
                    issue_rand(i);
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                    void'(exp_q[i].pop_back());
                end
            end
            cycle();
        end
        wait_quiet("rand_done", 2000);
        n = 0;
        for (int i = 0; i < NREQ; i++) n += acc_cnt[i];
        check("loads_match_accepts", 32'(load_cnt), 32'(n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
